slave_node_ctrl: RTL
====================

// Module: slave_node_ctrl
// PURPOSE
//  Control core of the next-generation cluster slave: one async serial link feeds NUM_HASHERS local hashers.
//  Assembles 44-byte work packets from the UART receiver and broadcasts them to all hashers.
//  Captures golden nonces from every hasher, arbitrates them round-robin into a result FIFO,
//  and serialises each nonce as 4 bytes to the UART transmitter. Hashers and UART cores are instantiated beside it in the top level.
// PARAMETERS
//  NUM_HASHERS      4   local hasher count (1..16); top gives hasher i nonce_start=LOCAL_NONCE_START+i
//  TOTAL_MINERS     1   cluster-wide hasher count = nonce stride; top level only, no internal use
//  LOCAL_NONCE_START 0  first nonce offset of this node; top level only
//  FIFO_DEPTH_LOG2  3   result FIFO depth = 2**FIFO_DEPTH_LOG2 entries of 32 bits
// PORTS
//  hash_clk      in   1                 sole clock
//  reset_button  in   1                 asynchronous, active-low reset
//  rx_data       in   8                 received byte
//  rx_valid      in   1                 1-cycle strobe, rx_data valid
//  work_midstate out  256               broadcast midstate (bytes 0..31 of packet)
//  work_data     out  96                broadcast data tail (bytes 32..43)
//  work_load     out  1                 1-cycle pulse, new work valid
//  golden_nonce  in   32*NUM_HASHERS    hasher i nonce at [32i+31:32i]
//  golden_valid  in   NUM_HASHERS       1-cycle strobe per hasher
//  tx_data       out  8                 byte to transmit
//  tx_start      out  1                 1-cycle strobe to UART TX
//  tx_busy       in   1                 UART TX busy
//  drop_count    out  8                 saturating count of overwritten nonces
// BEHAVIOUR
//  Reset: all outputs 0; byte counter 0; pending bits clear; FIFO empty; rr pointer 0; TX FSM IDLE.
//  RX: each rx_valid shifts rx_data into a 352-bit register, MSB-first (first byte -> bits 351:344).
//   Byte counter counts 0..43. On the 44th byte, {work_midstate,work_data} updates the next cycle with work_load=1 for one cycle.
//   The counter then wraps to 0. Outputs hold between packets.
//  Capture: per hasher, one 32-bit hold reg + pending bit; golden_valid[i] loads it, sets pending.
//   golden_valid[i] while pending[i] set and not drained that cycle: overwrite, drop_count+1 (saturates at 255).
//  Arbiter: each cycle, if FIFO not full, grant the first pending hasher at or after rr pointer (mod NUM_HASHERS).
//   Push its nonce and clear its pending bit; rr pointer = grant+1. At most one push/cycle.
//   Same-cycle grant and new golden_valid on that hasher: the new nonce is kept pending, with no drop.
//  FIFO: 1-cycle write-to-read latency; simultaneous push+pop allowed when full (pop frees, push accepted next cycle only).
//  TX FSM: IDLE -(FIFO non-empty)-> LOAD (pop word into shift reg) -> SEND (tx_start=1, tx_data=MSB byte) -> GAP (1 cycle, tx_busy ignored)
//   -> WAIT (until tx_busy=0) -> SEND for the next byte, or IDLE after the 4th byte. Bytes go MSB-first.
//  Latency: golden_valid to first tx_start is 4 cycles with an empty system and tx_busy=0.
//  Reset mid-operation returns all state to reset values immediately; a partial packet or partial nonce is discarded.
// CONFIGURATION
//  NONCE_FLUSH_EN defined: the cycle work_load=1, FIFO and all pending bits clear.
//   golden_valid in that cycle is discarded and not counted. A word already in the TX shift reg completes.
//  Not defined: stale nonces are retained and transmitted normally (the host filters them).
// STRUCTURE
//  Package slave_pkg: WORK_BYTES=44, NONCE_W=32, WORK_W=352, TX state enum {IDLE,LOAD,SEND,GAP,WAIT}.
//  Sub-module nonce_fifo (param DEPTH_LOG2, 32-bit, push/pop/full/empty). All else lives in slave_node_ctrl.
// TESTING
//  1. Send 44 bytes 0x00..0x2B -> single work_load pulse; midstate[255:248]=0x00, data[7:0]=0x2B.
//  2. Send 43 bytes, reset, then 44 bytes 0xFF -> no pulse after the partial packet; all-ones work after the full packet.
//  3. NUM_HASHERS=4; golden_valid=4'b1111, nonces 0x11111111..0x44444444, tx_busy held 10 cycles per byte
//     -> 16 bytes emitted in order hasher0..3, MSB-first, drop_count=0.
//  4. FIFO_DEPTH_LOG2=1 with tx_busy stuck 1; strobe hasher2 four times -> FIFO fills, then pending overwrite; drop_count=1, last nonce kept.
//  5. Fill 300 overwrites -> drop_count saturates at 255.
//  6. NONCE_FLUSH_EN: queue 3 nonces, complete a packet mid-TX
//     -> current word finishes, remaining 2 never sent; without the macro, all 3 are sent.

Source files
------------

// File: rtl/slave_pkg.sv
// Shared constants and TX state encoding for the cluster slave control core.
// Pure declarations: no latency, no flow control.
package slave_pkg;
  localparam int WORK_BYTES = 44;
  localparam int NONCE_W    = 32;
  localparam int WORK_W     = 352;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, WAIT} tx_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {4'b0000, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction
endpackage

// File: rtl/nonce_fifo.sv
// 32-bit result FIFO, 2**DEPTH_LOG2 entries; write visible to the reader one cycle later.
// Push is ignored while full and pop while empty; flush empties it and wins over push/pop.
module nonce_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_dat,
  input  logic        pop,
  output logic [31:0] pop_dat,
  output logic        full,
  output logic        empty
);
  localparam int PW = DEPTH_LOG2 + 1;

  logic [31:0]   mem_q [2**DEPTH_LOG2];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
  assign pop_dat = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_dat;
  end
endmodule

// File: rtl/slave_node_ctrl.sv
// Slave control core: 44-byte work assembly/broadcast, round-robin nonce capture, 4-byte nonce TX.
// Nonce to first tx_start is 4 cycles; TX waits on tx_busy; NONCE_FLUSH_EN drops stale nonces on new work.
module slave_node_ctrl
  import slave_pkg::*;
#(
  parameter int NUM_HASHERS       = 4,
  parameter int TOTAL_MINERS      = 1,
  parameter int LOCAL_NONCE_START = 0,
  parameter int FIFO_DEPTH_LOG2   = 3
) (
  input  logic                          hash_clk,
  input  logic                          reset_button,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [255:0]                  work_midstate,
  output logic [95:0]                   work_data,
  output logic                          work_load,
  input  logic [32*NUM_HASHERS-1:0]     golden_nonce,
  input  logic [NUM_HASHERS-1:0]        golden_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [7:0]                    drop_count
);
  localparam int RR_W = (NUM_HASHERS > 1) ? $clog2(NUM_HASHERS) : 1;

  if (NUM_HASHERS < 1 || NUM_HASHERS > 16 || TOTAL_MINERS < 1 || LOCAL_NONCE_START < 0) begin : g_bad_cfg
    $error("slave_node_ctrl: illegal hasher configuration");
  end

  // Holds the previous 43 bytes; the 44th byte is appended directly into the work outputs.
  logic [WORK_W-9:0]   rx_sh_q, rx_sh_d;
  logic [5:0]          byte_cnt_q, byte_cnt_d;
  logic [255:0]        midstate_q, midstate_d;
  logic [95:0]         wdata_q, wdata_d;
  logic                work_load_q, work_load_d;

  logic [NONCE_W-1:0]  hold_q [NUM_HASHERS];
  logic [NONCE_W-1:0]  hold_d [NUM_HASHERS];
  logic [NUM_HASHERS-1:0] pend_q, pend_d;
  logic [7:0]          drop_q, drop_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic                grant_vld;
  logic [RR_W-1:0]     grant_idx;
  logic [4:0]          ndrop;

  tx_state_e           tx_state_q, tx_state_d;
  logic [NONCE_W-1:0]  tx_sh_q, tx_sh_d;
  logic [1:0]          tx_cnt_q, tx_cnt_d;

  logic                flush;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [NONCE_W-1:0]  fifo_dat;

`ifdef NONCE_FLUSH_EN
  assign flush = work_load_q;
`else
  assign flush = 1'b0;
`endif

  assign work_midstate = midstate_q;
  assign work_data     = wdata_q;
  assign work_load     = work_load_q;
  assign drop_count    = drop_q;

  always_comb begin
    rx_sh_d     = rx_sh_q;
    byte_cnt_d  = byte_cnt_q;
    midstate_d  = midstate_q;
    wdata_d     = wdata_q;
    work_load_d = 1'b0;
    if (rx_valid) begin
      rx_sh_d = {rx_sh_q[WORK_W-17:0], rx_data};
      if (byte_cnt_q == 6'(WORK_BYTES - 1)) begin
        byte_cnt_d              = '0;
        {midstate_d, wdata_d}   = {rx_sh_q, rx_data};
        work_load_d             = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 6'd1;
      end
    end
  end

  // Round-robin search starting at rr_q; no grant while the FIFO is full or being flushed.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_HASHERS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_HASHERS) idx = idx - NUM_HASHERS;
      if (!grant_vld && pend_q[idx] && !fifo_full && !flush) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(idx);
      end
    end
    rr_d = rr_q;
    if (grant_vld) rr_d = (int'(grant_idx) == NUM_HASHERS - 1) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    ndrop  = '0;
    for (int i = 0; i < NUM_HASHERS; i++) begin
      if (grant_vld && grant_idx == RR_W'(i)) pend_d[i] = 1'b0;
      if (golden_valid[i] && !flush) begin
        hold_d[i] = golden_nonce[32*i +: 32];
        pend_d[i] = 1'b1;
        if (pend_q[i] && !(grant_vld && grant_idx == RR_W'(i))) ndrop = ndrop + 5'd1;
      end
    end
    if (flush) pend_d = '0;
    drop_d = sat_add8(drop_q, ndrop);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    fifo_pop   = 1'b0;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    case (tx_state_q)
      IDLE: if (!fifo_empty && !flush) tx_state_d = LOAD;
      LOAD: begin
        fifo_pop   = 1'b1;
        tx_sh_d    = fifo_dat;
        tx_cnt_d   = '0;
        tx_state_d = SEND;
      end
      SEND: begin
        tx_start   = 1'b1;
        tx_data    = tx_sh_q[31:24];
        tx_sh_d    = {tx_sh_q[23:0], 8'h00};
        tx_cnt_d   = tx_cnt_q + 2'd1;
        tx_state_d = GAP;
      end
      GAP:  tx_state_d = WAIT;
      // tx_cnt wraps to 0 once the fourth byte has gone out
      WAIT: if (!tx_busy) tx_state_d = (tx_cnt_q == 2'd0) ? IDLE : SEND;
      default: tx_state_d = IDLE;
    endcase
  end

  nonce_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk      (hash_clk),
    .rst_n    (reset_button),
    .flush    (flush),
    .push     (grant_vld),
    .push_dat (hold_q[grant_idx]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge hash_clk or negedge reset_button) begin
    if (!reset_button) begin
      rx_sh_q     <= '0;
      byte_cnt_q  <= '0;
      midstate_q  <= '0;
      wdata_q     <= '0;
      work_load_q <= 1'b0;
      for (int i = 0; i < NUM_HASHERS; i++) hold_q[i] <= '0;
      pend_q      <= '0;
      drop_q      <= '0;
      rr_q        <= '0;
      tx_state_q  <= IDLE;
      tx_sh_q     <= '0;
      tx_cnt_q    <= '0;
    end else begin
      rx_sh_q     <= rx_sh_d;
      byte_cnt_q  <= byte_cnt_d;
      midstate_q  <= midstate_d;
      wdata_q     <= wdata_d;
      work_load_q <= work_load_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      rr_q        <= rr_d;
      tx_state_q  <= tx_state_d;
      tx_sh_q     <= tx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end
endmodule
